// File: rtl/aes_pkg.sv
// Shared AES decrypt-side types, constants and GF(2^8) helpers.
// Constant multiplies are built only from chained xtime terms.
package aes_pkg;

  localparam logic [7:0] AES_POLY  = 8'h1b;
  localparam logic [7:0] INV_C_0E  = 8'h0e;
  localparam logic [7:0] INV_C_0B  = 8'h0b;
  localparam logic [7:0] INV_C_0D  = 8'h0d;
  localparam logic [7:0] INV_C_09  = 8'h09;

  typedef logic [31:0]  column_t;
  typedef logic [127:0] state_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mix_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

  // Multiply by a constant below 16: XOR of b, x2, x4, x8 selected by coefficient bits.
  function automatic logic [7:0] gmul_const(input logic [7:0] b, input logic [3:0] coeff);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (coeff[0] ? b  : 8'h00) ^ (coeff[1] ? x2 : 8'h00) ^
           (coeff[2] ? x4 : 8'h00) ^ (coeff[3] ? x8 : 8'h00);
  endfunction

endpackage

// File: rtl/inv_mixcolumn.sv
// Combinational InvMixColumns for one 32-bit column (byte 0 in bits [7:0]).
module inv_mixcolumn
  import aes_pkg::*;
(
  input  column_t col_in,
  output column_t col_out
);

  logic [7:0] b0, b1, b2, b3;

  assign b0 = col_in[7:0];
  assign b1 = col_in[15:8];
  assign b2 = col_in[23:16];
  assign b3 = col_in[31:24];

  assign col_out[7:0]   = gmul_const(b0, INV_C_0E[3:0]) ^ gmul_const(b1, INV_C_0B[3:0]) ^
                          gmul_const(b2, INV_C_0D[3:0]) ^ gmul_const(b3, INV_C_09[3:0]);
  assign col_out[15:8]  = gmul_const(b0, INV_C_09[3:0]) ^ gmul_const(b1, INV_C_0E[3:0]) ^
                          gmul_const(b2, INV_C_0B[3:0]) ^ gmul_const(b3, INV_C_0D[3:0]);
  assign col_out[23:16] = gmul_const(b0, INV_C_0D[3:0]) ^ gmul_const(b1, INV_C_09[3:0]) ^
                          gmul_const(b2, INV_C_0E[3:0]) ^ gmul_const(b3, INV_C_0B[3:0]);
  assign col_out[31:24] = gmul_const(b0, INV_C_0B[3:0]) ^ gmul_const(b1, INV_C_0D[3:0]) ^
                          gmul_const(b2, INV_C_09[3:0]) ^ gmul_const(b3, INV_C_0E[3:0]);

endmodule

// File: rtl/inv_mixcolumns_state.sv
// Iterative InvMixColumns over a 128-bit state, COLS_PER_CYCLE columns per BUSY cycle.
//   state | meaning
//   IDLE  | waiting for a state, in_ready=1
//   BUSY  | transforming columns of the work register in place
//   DONE  | result held on out_data until out_ready; may accept the next state
module inv_mixcolumns_state
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cpc
    $error("inv_mixcolumns_state: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  // Step of 4 wraps to 0 in the 2-bit counter, so CPC=4 finishes in one cycle.
  localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE % 4);
  localparam logic [1:0] LAST_CNT = 2'(4 - COLS_PER_CYCLE);

  mix_state_e state_q, state_d;
  logic [1:0] col_cnt_q, col_cnt_d;
  state_t     work_q, work_d, work_mixed;

  logic [1:0] col_idx [COLS_PER_CYCLE];
  column_t    mix_in  [COLS_PER_CYCLE];
  column_t    mix_out [COLS_PER_CYCLE];

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
    assign col_idx[g] = col_cnt_q + 2'(g);
    assign mix_in[g]  = work_q[32*col_idx[g] +: 32];
    inv_mixcolumn u_inv_mixcolumn (
      .col_in  (mix_in[g]),
      .col_out (mix_out[g])
    );
  end

  always_comb begin
    work_mixed = work_q;
    for (int g = 0; g < COLS_PER_CYCLE; g++) begin
      work_mixed[32*col_idx[g] +: 32] = mix_out[g];
    end
  end

  always_comb begin
    state_d   = state_q;
    col_cnt_d = col_cnt_q;
    work_d    = work_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          work_d    = in_data;
          col_cnt_d = 2'd0;
          state_d   = ST_BUSY;
        end
      end
      ST_BUSY: begin
        work_d    = work_mixed;
        col_cnt_d = col_cnt_q + CNT_STEP;
        if (col_cnt_q == LAST_CNT) state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            work_d    = in_data;
            col_cnt_d = 2'd0;
            state_d   = ST_BUSY;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      col_cnt_q <= 2'd0;
      work_q    <= '0;
    end else begin
      state_q   <= state_d;
      col_cnt_q <= col_cnt_d;
      work_q    <= work_d;
    end
  end

  assign out_data = work_q;

endmodule
